// File: rtl/lcm_reg_pkg.sv
// Shared register-map numbers and read-FSM encoding for the LCM
// register read/write blocks.
package lcm_reg_pkg;

    localparam logic [7:0] REG_ID       = 8'd0;
    localparam logic [7:0] REG_PROTO    = 8'd4;
    localparam logic [7:0] REG_RATE     = 8'd7;
    localparam logic [7:0] REG_START    = 8'd8;
    localparam logic [7:0] REG_MODEL    = 8'd9;
    localparam logic [7:0] REG_PKT_IN   = 8'd13;
    localparam logic [7:0] REG_PKT_OUT  = 8'd14;
    localparam logic [7:0] REG_SSM_DATA = 8'd15;
    localparam logic [7:0] REG_SSM_VLD  = 8'd16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_RESP = 2'd2
    } rd_state_e;

endpackage

// File: rtl/lcm_rd_clr_cnt.sv
// 64-bit saturating event counter, cleared when its register is read.
// An increment landing on the clear cycle leaves the count at 1.
module lcm_rd_clr_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        clr,
    output logic [63:0] cnt
);

    logic [63:0] base;
    logic        sat;

    // Start from zero on a clear so a coincident increment is kept.
    always_comb begin
        base = clr ? 64'd0 : cnt;
        sat  = &base;
    end

    // Count register; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 64'd0;
        end else if (inc && !sat) begin
            cnt <= base + 64'd1;
        end else begin
            cnt <= base;
        end
    end

endmodule

// File: rtl/lcm_reg_rd.sv
// LCM register read port: fixed two-cycle request-to-ack read of
// identity, writer readback, packet counters and the SSM capture.
module lcm_reg_rd
    import lcm_reg_pkg::*;
#(
    parameter PLATFORM = "Xilinx-OpenBox-S4",
    parameter logic [7:0]  LMID    = 8'd31,
    parameter logic [15:0] VERSION = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_reg_req,
    input  logic [7:0]  rd_reg_n,
    output logic        rd_reg_ack,
    output logic [63:0] rd_reg_n_value,
    input  logic [7:0]  protocol_type,
    input  logic [63:0] sent_rate_n_reg,
    input  logic        sent_start,
    input  logic        sent_model,
    input  logic        pkt_in_inc,
    input  logic        pkt_out_inc,
    input  logic [63:0] ssm2lcm_data,
    input  logic        ssm2lcm_data_valid
);

    rd_state_e   state_q;
    rd_state_e   state_d;
    logic [7:0]  reg_num_q;
    logic [63:0] mux_val;
    logic        sel_cyc;
    logic        in_clr;
    logic        out_clr;
    logic        ssm_clr;
    logic [63:0] pkt_in_cnt;
    logic [63:0] pkt_out_cnt;
    logic [63:0] ssm_data_cap;
    logic        ssm_cap_valid;
    logic        unused_platform;

    // The board tag is informational and drives no logic.
    assign unused_platform = ^PLATFORM;

    // Decode which clear-on-read side effect the SEL cycle carries.
    always_comb begin
        sel_cyc = (state_q == ST_SEL);
        in_clr  = sel_cyc && (reg_num_q == REG_PKT_IN);
        out_clr = sel_cyc && (reg_num_q == REG_PKT_OUT);
        ssm_clr = sel_cyc && (reg_num_q == REG_SSM_DATA);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; requests outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (rd_reg_req) state_d = ST_SEL;
            ST_SEL:  state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the register number when a request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_num_q <= 8'd0;
        end else if (state_q == ST_IDLE && rd_reg_req) begin
            reg_num_q <= rd_reg_n;
        end
    end

    // Register map; unmapped numbers read as zero.
    always_comb begin
        mux_val = 64'd0;
        unique case (1'b1)
            (reg_num_q == REG_ID):
                mux_val = {40'd0, VERSION, LMID};
            (reg_num_q == REG_PROTO):
                mux_val = {56'd0, protocol_type};
            (reg_num_q == REG_RATE):
                mux_val = sent_rate_n_reg;
            (reg_num_q == REG_START):
                mux_val = {63'd0, sent_start};
            (reg_num_q == REG_MODEL):
                mux_val = {63'd0, sent_model};
            (reg_num_q == REG_PKT_IN):
                mux_val = pkt_in_cnt;
            (reg_num_q == REG_PKT_OUT):
                mux_val = pkt_out_cnt;
            (reg_num_q == REG_SSM_DATA):
                mux_val = ssm_data_cap;
            (reg_num_q == REG_SSM_VLD):
                mux_val = {63'd0, ssm_cap_valid};
            default:
                mux_val = 64'd0;
        endcase
    end

    // Data and ack leave SEL together so the value only moves with ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_reg_ack     <= 1'b0;
            rd_reg_n_value <= 64'd0;
        end else begin
            rd_reg_ack <= sel_cyc;
            if (sel_cyc) begin
                rd_reg_n_value <= mux_val;
            end
        end
    end

    // SSM capture; a fresh capture beats a read-clear of the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssm_data_cap  <= 64'd0;
            ssm_cap_valid <= 1'b0;
        end else if (ssm2lcm_data_valid) begin
            ssm_data_cap  <= ssm2lcm_data;
            ssm_cap_valid <= 1'b1;
        end else if (ssm_clr) begin
            ssm_cap_valid <= 1'b0;
        end
    end

    lcm_rd_clr_cnt u_pkt_in_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pkt_in_inc),
        .clr   (in_clr),
        .cnt   (pkt_in_cnt)
    );

    lcm_rd_clr_cnt u_pkt_out_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pkt_out_inc),
        .clr   (out_clr),
        .cnt   (pkt_out_cnt)
    );

endmodule

// File: tb/tb_lcm_reg_rd.sv
// Scoreboard bench for lcm_reg_rd: directed scenarios plus random
// traffic against a cycle-level reference of the register map.
module tb_lcm_reg_rd;

    localparam logic [7:0]  LMID    = 8'd31;
    localparam logic [15:0] VERSION = 16'h0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_reg_req;
    logic [7:0]  rd_reg_n;
    logic        rd_reg_ack;
    logic [63:0] rd_reg_n_value;
    logic [7:0]  protocol_type;
    logic [63:0] sent_rate_n_reg;
    logic        sent_start;
    logic        sent_model;
    logic        pkt_in_inc;
    logic        pkt_out_inc;
    logic [63:0] ssm2lcm_data;
    logic        ssm2lcm_data_valid;

    always #5 clk = ~clk;

    lcm_reg_rd #(
        .PLATFORM ("Xilinx-OpenBox-S4"),
        .LMID     (LMID),
        .VERSION  (VERSION)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rd_reg_req         (rd_reg_req),
        .rd_reg_n           (rd_reg_n),
        .rd_reg_ack         (rd_reg_ack),
        .rd_reg_n_value     (rd_reg_n_value),
        .protocol_type      (protocol_type),
        .sent_rate_n_reg    (sent_rate_n_reg),
        .sent_start         (sent_start),
        .sent_model         (sent_model),
        .pkt_in_inc         (pkt_in_inc),
        .pkt_out_inc        (pkt_out_inc),
        .ssm2lcm_data       (ssm2lcm_data),
        .ssm2lcm_data_valid (ssm2lcm_data_valid)
    );

    typedef struct {
        logic [63:0] val;
        int          cyc;
        int          rnum;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    logic [63:0] m_in = 64'd0;
    logic [63:0] m_out = 64'd0;
    logic [63:0] m_cap = 64'd0;
    logic        m_vld = 1'b0;
    bit          pend = 1'b0;
    int          pend_reg = 0;
    int          pend_cyc = 0;
    int          free_cyc = 0;
    logic [63:0] last_val = 64'd0;

    function automatic logic [63:0] ref_read(int r);
        case (r)
            0:  return {40'd0, VERSION, LMID};
            4:  return {56'd0, protocol_type};
            7:  return sent_rate_n_reg;
            8:  return {63'd0, sent_start};
            9:  return {63'd0, sent_model};
            13: return m_in;
            14: return m_out;
            15: return m_cap;
            16: return {63'd0, m_vld};
            default: return 64'd0;
        endcase
    endfunction

    // Reference: a read accepted at edge A is answered at edge A+1,
    // and the port is busy until edge A+3.
    always @(posedge clk) begin : model
        bit r13, r14, r15;
        cyc++;
        r13 = 1'b0;
        r14 = 1'b0;
        r15 = 1'b0;
        if (!rst_n) begin
            m_in = 64'd0;
            m_out = 64'd0;
            m_cap = 64'd0;
            m_vld = 1'b0;
            pend = 1'b0;
            free_cyc = cyc;
            sbq.delete();
        end else begin
            if (pend && cyc == pend_cyc) begin
                sbq.push_back('{ref_read(pend_reg), cyc, pend_reg});
                r13 = (pend_reg == 13);
                r14 = (pend_reg == 14);
                r15 = (pend_reg == 15);
                pend = 1'b0;
            end
            if (rd_reg_req && cyc >= free_cyc) begin
                pend = 1'b1;
                pend_reg = int'(rd_reg_n);
                pend_cyc = cyc + 1;
                free_cyc = cyc + 3;
            end
            if (r13) m_in = 64'd0;
            if (pkt_in_inc && m_in != '1) m_in = m_in + 64'd1;
            if (r14) m_out = 64'd0;
            if (pkt_out_inc && m_out != '1) m_out = m_out + 64'd1;
            if (ssm2lcm_data_valid) begin
                m_cap = ssm2lcm_data;
                m_vld = 1'b1;
            end else if (r15) begin
                m_vld = 1'b0;
            end
        end
    end

    // Monitor: pop on every ack, otherwise the output must hold.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            vectors++;
            if (rd_reg_ack !== 1'b0 || rd_reg_n_value !== 64'd0) begin
                miscompares++;
                $display("FAIL reset_state: ack=%b value=%h required ack=0 value=0",
                         rd_reg_ack, rd_reg_n_value);
            end
            last_val = 64'd0;
        end else begin
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_ack: reg %0d no ack at cycle %0d required %h",
                         e.rnum, e.cyc, e.val);
            end
            vectors++;
            if (rd_reg_ack === 1'b1) begin
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_ack: cycle %0d value %h required no ack",
                             cyc, rd_reg_n_value);
                    last_val = rd_reg_n_value;
                end else begin
                    e = sbq.pop_front();
                    if (e.cyc != cyc || rd_reg_n_value !== e.val) begin
                        miscompares++;
                        $display("FAIL read_reg%0d: got %h at cycle %0d required %h at cycle %0d",
                                 e.rnum, rd_reg_n_value, cyc, e.val, e.cyc);
                    end
                    last_val = e.val;
                end
            end else if (rd_reg_ack !== 1'b0 || rd_reg_n_value !== last_val) begin
                miscompares++;
                $display("FAIL hold_value: ack=%b value=%h required ack=0 value=%h",
                         rd_reg_ack, rd_reg_n_value, last_val);
                last_val = rd_reg_n_value;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        protocol_type = 8'($urandom);
        sent_rate_n_reg = {$urandom, $urandom};
        sent_start = 1'($urandom);
        sent_model = 1'($urandom);
    endtask

    task automatic rd(input int r);
        rd_reg_req = 1'b1;
        rd_reg_n = 8'(r);
        step();
        rd_reg_req = 1'b0;
        step();
        step();
    endtask

    function automatic int pick_reg();
        int regs[10] = '{0, 4, 7, 8, 9, 13, 14, 15, 16, 99};
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 255));
        return regs[$urandom_range(0, 9)];
    endfunction

    initial begin
        rst_n = 1'b0;
        rd_reg_req = 1'b0;
        rd_reg_n = 8'd0;
        protocol_type = 8'd0;
        sent_rate_n_reg = 64'd0;
        sent_start = 1'b0;
        sent_model = 1'b0;
        pkt_in_inc = 1'b0;
        pkt_out_inc = 1'b0;
        ssm2lcm_data = 64'd0;
        ssm2lcm_data_valid = 1'b0;
        repeat (3) step();

        // Identity read right after reset release.
        rst_n = 1'b1;
        rd(0);

        // Five input packets, then two reads of the counter.
        pkt_in_inc = 1'b1;
        repeat (5) step();
        pkt_in_inc = 1'b0;
        rd(13);
        rd(13);

        // Output strobe held across the clearing read.
        pkt_out_inc = 1'b1;
        step();
        rd(14);
        pkt_out_inc = 1'b0;
        rd(14);

        // Second request while busy is dropped.
        rd_reg_req = 1'b1;
        rd_reg_n = 8'd7;
        step();
        rd_reg_n = 8'd0;
        step();
        rd_reg_req = 1'b0;
        step();
        step();

        // SSM capture and read-clear of its flag.
        ssm2lcm_data = 64'hA5A5_0000_1234_5678;
        ssm2lcm_data_valid = 1'b1;
        step();
        ssm2lcm_data_valid = 1'b0;
        rd(16);
        rd(15);
        rd(16);

        // Capture coinciding with the clearing read keeps the flag.
        ssm2lcm_data_valid = 1'b1;
        step();
        ssm2lcm_data_valid = 1'b0;
        rd_reg_req = 1'b1;
        rd_reg_n = 8'd15;
        step();
        rd_reg_req = 1'b0;
        ssm2lcm_data = 64'h0123_4567_89AB_CDEF;
        ssm2lcm_data_valid = 1'b1;
        step();
        ssm2lcm_data_valid = 1'b0;
        step();
        rd(16);
        rd(15);

        // Reset in the middle of a read aborts it.
        rd_reg_req = 1'b1;
        rd_reg_n = 8'd9;
        step();
        rd_reg_req = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        rd(99);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rd_reg_req = ($urandom_range(0, 2) == 0);
            rd_reg_n = 8'(pick_reg());
            pkt_in_inc = 1'($urandom);
            pkt_out_inc = 1'($urandom);
            ssm2lcm_data_valid = ($urandom_range(0, 7) == 0);
            ssm2lcm_data = {$urandom, $urandom};
            step();
        end
        rd_reg_req = 1'b0;
        pkt_in_inc = 1'b0;
        pkt_out_inc = 1'b0;
        ssm2lcm_data_valid = 1'b0;
        rd(13);
        rd(14);
        rd(16);
        repeat (5) step();

        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d reads pending required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
